// File: rtl/sync_fifo_pkg.sv
// Shared helpers and default thresholds for the single-clock flagged FIFO.
package sync_fifo_pkg;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // almost_full default sits this many words below DEPTH
  localparam int DEF_AFULL_MARGIN  = 2;
  localparam int DEF_AEMPTY_THRESH = 2;

endpackage

// File: rtl/sync_fifo_mem.sv
// Single-clock dual-port storage; read port is registered, or combinational for FWFT.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  if (FWFT != 0) begin : g_fwft
    assign rdata = mem_q[raddr];
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    // rdata holds between reads
    always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem_q[raddr];
    end

    always_ff @(posedge clk) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
  end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags, error pulses and optional FWFT.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = fifo_depth(ADDR_WIDTH) - DEF_AFULL_MARGIN,
  parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH,
  parameter int FWFT          = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  winc,
  input  logic                  rinc,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THRESH);

  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $fatal(1, "sync_fifo_flags: AFULL_THRESH %0d outside 1..%0d", AFULL_THRESH, DEPTH);
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $fatal(1, "sync_fifo_flags: AEMPTY_THRESH %0d outside 0..%0d", AEMPTY_THRESH, DEPTH - 1);
  end

  logic [CNT_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic             wr_ok, rd_ok;

  // Acceptance uses this cycle's registered flags, so full+both lets only the read through
  assign wr_ok = winc & ~wfull;
  assign rd_ok = rinc & ~rempty;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = winc & wfull;
    underflow_d = rinc & rempty;
    if (wr_ok) wptr_d = wptr_q + 1'b1;
    if (rd_ok) rptr_d = rptr_q + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign count        = count_q;
  assign wfull        = (count_q == DEPTH_C);
  assign rempty       = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .FWFT       (FWFT)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wptr_q[ADDR_WIDTH-1:0]),
    .wdata (wdata),
    .re    (rd_ok),
    .raddr (rptr_q[ADDR_WIDTH-1:0]),
    .rdata (rdata)
  );

  if (FWFT != 0) begin : g_rv_fwft
    assign rvalid = ~rempty;
  end else begin : g_rv_reg
    logic rvalid_q, rvalid_d;
    always_comb rvalid_d = rd_ok;
    always_ff @(posedge clk) begin
      if (rst) rvalid_q <= 1'b0;
      else     rvalid_q <= rvalid_d;
    end
    assign rvalid = rvalid_q;
  end

  logic [CNT_W-1:0] occ;
  assign occ = wptr_q - rptr_q;

  a_count_matches_ptrs: assert property (@(posedge clk) disable iff (rst) count_q == occ);

endmodule
